// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the three-requester memory port arbiter:
// requester IDs, default widths and the round-robin successor helper.
package mem_arb_pkg;

  localparam int AW_DEF = 6;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    REQ_LD = 2'd0,
    REQ_DM = 2'd1,
    REQ_IF = 2'd2
  } req_id_e;

  // Ring order LD -> DM -> IF -> LD; the unused code 3 falls back to LD.
  function automatic req_id_e rr_next(req_id_e id);
    case (id)
      REQ_LD:  return REQ_DM;
      REQ_DM:  return REQ_IF;
      default: return REQ_LD;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-macro signal bundle for mem_port_arbiter.
// slave = arbiter view, master = requesters plus memory macro view.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_gnt;
  logic          ld_rvalid;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;

  logic [DW-1:0] rdata;
  logic          stall;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  ld_req, ld_we, ld_addr, ld_wdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  if_req, if_addr,
    input  mem_rdata,
    output ld_gnt, ld_rvalid, dm_gnt, dm_rvalid, if_gnt, if_rvalid,
    output rdata, stall,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output ld_req, ld_we, ld_addr, ld_wdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output if_req, if_addr,
    output mem_rdata,
    input  ld_gnt, ld_rvalid, dm_gnt, dm_rvalid, if_gnt, if_rvalid,
    input  rdata, stall,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: searches starting at the
// requester after 'last' and returns a one-hot grant plus winner ID.
module rr_pick3
  import mem_arb_pkg::*;
(
  input  logic [2:0] req,
  input  req_id_e    last,
  output logic [2:0] gnt,
  output req_id_e    winner,
  output logic       valid
);

  req_id_e p0, p1, p2;

  always_comb begin
    p0     = rr_next(last);
    p1     = rr_next(p0);
    p2     = rr_next(p1);
    winner = last;
    valid  = 1'b0;
    if (req[p0]) begin
      winner = p0;
      valid  = 1'b1;
    end else if (req[p1]) begin
      winner = p1;
      valid  = 1'b1;
    end else if (req[p2]) begin
      winner = p2;
      valid  = 1'b1;
    end
    gnt = valid ? (3'b001 << winner) : 3'b000;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between the
// loader, data access and instruction fetch; 2-cycle read return.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input logic               clk_main,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  logic [2:0] req_vec, pick_gnt, gnt_vec;
  req_id_e    winner;
  logic       pick_valid, grant_ok;

  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  req_id_e       last_q, last_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          cmd_we_q, cmd_we_d;
  logic [AW-1:0] cmd_addr_q, cmd_addr_d;
  logic [DW-1:0] cmd_wdata_q, cmd_wdata_d;
  req_id_e       cmd_owner_q, cmd_owner_d;
  logic          rd_valid_q, rd_valid_d;
  req_id_e       rd_owner_q, rd_owner_d;
  logic [DW-1:0] rdata_q, rdata_d;

  assign req_vec = {bus.if_req, bus.dm_req, bus.ld_req};

  rr_pick3 u_pick (
    .req    (req_vec),
    .last   (last_q),
    .gnt    (pick_gnt),
    .winner (winner),
    .valid  (pick_valid)
  );

  // No grants are offered while reset is held, even with requests pending.
  assign gnt_vec  = reset ? pick_gnt : 3'b000;
  assign grant_ok = pick_valid & reset;

  always_comb begin
    sel_we    = bus.ld_we;
    sel_addr  = bus.ld_addr;
    sel_wdata = bus.ld_wdata;
    case (winner)
      REQ_DM: begin
        sel_we    = bus.dm_we;
        sel_addr  = bus.dm_addr;
        sel_wdata = bus.dm_wdata;
      end
      REQ_IF: begin
        sel_we    = 1'b0;
        sel_addr  = bus.if_addr;
        sel_wdata = cmd_wdata_q;
      end
      default: ;
    endcase
  end

  // Memory data arrives the cycle after mem_en, so it is passed straight
  // through on the return cycle and captured to hold rdata afterwards.
  always_comb begin
    last_d      = grant_ok ? winner : last_q;
    cmd_valid_d = grant_ok;
    cmd_we_d    = grant_ok & sel_we;
    cmd_addr_d  = grant_ok ? sel_addr : cmd_addr_q;
    cmd_wdata_d = grant_ok ? sel_wdata : cmd_wdata_q;
    cmd_owner_d = grant_ok ? winner : cmd_owner_q;
    rd_valid_d  = cmd_valid_q & ~cmd_we_q;
    rd_owner_d  = cmd_owner_q;
    rdata_d     = rd_valid_q ? bus.mem_rdata : rdata_q;
  end

  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      last_q      <= REQ_LD;
      cmd_valid_q <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_owner_q <= REQ_LD;
      rd_valid_q  <= 1'b0;
      rd_owner_q  <= REQ_LD;
      rdata_q     <= '0;
    end else begin
      last_q      <= last_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_owner_q <= cmd_owner_d;
      rd_valid_q  <= rd_valid_d;
      rd_owner_q  <= rd_owner_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.ld_gnt    = gnt_vec[0];
  assign bus.dm_gnt    = gnt_vec[1];
  assign bus.if_gnt    = gnt_vec[2];
  assign bus.stall     = (bus.dm_req & ~gnt_vec[1]) | (bus.if_req & ~gnt_vec[2]);

  assign bus.mem_en    = cmd_valid_q;
  assign bus.mem_we    = cmd_valid_q & cmd_we_q;
  assign bus.mem_addr  = cmd_addr_q;
  assign bus.mem_wdata = cmd_wdata_q;

  assign bus.ld_rvalid = rd_valid_q & (rd_owner_q == REQ_LD);
  assign bus.dm_rvalid = rd_valid_q & (rd_owner_q == REQ_DM);
  assign bus.if_rvalid = rd_valid_q & (rd_owner_q == REQ_IF);
  assign bus.rdata     = rdata_d;

endmodule
